// File: rtl/mux_reg_8x8.sv
// Eight-entry by 8-bit register file with one write port, a gated combinational read port
// and a 64-bit scan chain threaded through all storage bits (chain bit k = 8*entry + bit).
module mux_reg_8x8 (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] din,
    input  logic       en_in,
    input  logic [2:0] wr_addr,
    input  logic       en_out,
    input  logic [2:0] rd_addr,
    output logic [7:0] dout,
    input  logic       tc,
    input  logic       td,
    output logic       tq
);

    localparam int unsigned WIDTH = 8;
    localparam int unsigned BITS  = 64;
    localparam int unsigned IW    = 6;

    logic [BITS-1:0] chain_q;
    logic [BITS-1:0] chain_d;
    logic [IW-1:0]   wr_base;
    logic [IW-1:0]   rd_base;

    // Entry e occupies chain bits [8e+7:8e], so the base index is addr*8.
    assign wr_base = {wr_addr, 3'b000};
    assign rd_base = {rd_addr, 3'b000};

    // Scan shift has priority over a functional write.
    always_comb begin
        chain_d = chain_q;
        if (tc) begin
            chain_d = {chain_q[BITS-2:0], td};
        end else if (en_in) begin
            chain_d[wr_base +: WIDTH] = din;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            chain_q <= '0;
        end else begin
            chain_q <= chain_d;
        end
    end

    // Read and scan-out are purely combinational from storage; no write-through bypass.
    assign dout = en_out ? chain_q[rd_base +: WIDTH] : WIDTH'(0);
    assign tq   = chain_q[BITS-1];

endmodule

// File: tb/tb_mux_reg_8x8.sv
// Scoreboarded bench for mux_reg_8x8: directed scenarios plus randomized traffic checked
// against a bit-array reference model; a monitor process drains expectations and compares.
`timescale 1ns/1ps
module tb_mux_reg_8x8;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] din;
    logic       en_in;
    logic [2:0] wr_addr;
    logic       en_out;
    logic [2:0] rd_addr;
    logic [7:0] dout;
    logic       tc;
    logic       td;
    logic       tq;

    always #10 clk = ~clk;

    mux_reg_8x8 dut (
        .clk    (clk),
        .reset  (reset),
        .din    (din),
        .en_in  (en_in),
        .wr_addr(wr_addr),
        .en_out (en_out),
        .rd_addr(rd_addr),
        .dout   (dout),
        .tc     (tc),
        .td     (td),
        .tq     (tq)
    );

    typedef struct {
        string      name;
        logic [7:0] dout;
        logic       tq;
    } exp_t;

    exp_t sb_q[$];
    event chk_ev;
    int   checks   = 0;
    int   failures = 0;

    // Reference model: 64 independent storage bits, index = 8*entry + bit.
    bit model_bits[64];

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < 64; k++) model_bits[k] <= 1'b0;
        end else if (tc) begin
            for (int k = 1; k < 64; k++) model_bits[k] <= model_bits[k-1];
            model_bits[0] <= td;
        end else if (en_in) begin
            for (int b = 0; b < 8; b++) model_bits[int'(wr_addr) * 8 + b] <= din[b];
        end
    end

    function automatic logic [7:0] model_byte(input int e);
        logic [7:0] v;
        for (int b = 0; b < 8; b++) v[b] = model_bits[e * 8 + b];
        return v;
    endfunction

    // Monitor: compares every queued expectation against the live DUT outputs.
    initial begin
        forever begin
            @(chk_ev);
            while (sb_q.size() > 0) begin
                exp_t e;
                e = sb_q.pop_front();
                checks++;
                if (dout !== e.dout) begin
                    failures++;
                    $display("FAIL %s: got dout=%h, expected dout=%h", e.name, dout, e.dout);
                end
                if (tq !== e.tq) begin
                    failures++;
                    $display("FAIL %s: got tq=%b, expected tq=%b", e.name, tq, e.tq);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a read, let it settle, then hand the expectation to the monitor.
    task automatic read_chk(input string nm, input logic [2:0] a, input logic en,
                            input logic [7:0] exp_d, input logic exp_t_q);
        rd_addr = a;
        en_out  = en;
        #1;
        sb_q.push_back('{nm, exp_d, exp_t_q});
        -> chk_ev;
        #1;
    endtask

    task automatic write(input logic [2:0] a, input logic [7:0] d);
        en_in   = 1'b1;
        wr_addr = a;
        din     = d;
        tick();
        en_in   = 1'b0;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; din = '0; en_in = 1'b0; wr_addr = '0;
        en_out = 1'b0; rd_addr = '0; tc = 1'b0; td = 1'b0;
        tick(); tick();
        read_chk("reset_state", 3'd0, 1'b1, 8'h00, 1'b0);
        reset = 1'b0;
        tick();

        // Reset clear: fill with FF, then assert reset mid-cycle and read before any edge.
        for (int i = 0; i < 8; i++) write(3'(i), 8'hFF);
        read_chk("fill_ff", 3'd4, 1'b1, 8'hFF, 1'b1);
        tick();
        reset = 1'b1;
        for (int i = 0; i < 8; i++) read_chk($sformatf("async_clear_%0d", i), 3'(i), 1'b1, 8'h00, 1'b0);
        tick();
        reset = 1'b0;
        tick();

        // Write and read back every entry, then gate the output off.
        for (int i = 0; i < 8; i++) write(3'(i), 8'h10 + 8'(i));
        for (int i = 0; i < 8; i++) read_chk($sformatf("rd_entry_%0d", i), 3'(i), 1'b1, 8'h10 + 8'(i), 1'b0);
        read_chk("en_out_off_3", 3'd3, 1'b0, 8'h00, 1'b0);
        read_chk("en_out_off_7", 3'd7, 1'b0, 8'h00, 1'b0);

        // Hold: no write for 5 edges despite changing din.
        write(3'd3, 8'hA5);
        wr_addr = 3'd3; din = 8'h5A; en_in = 1'b0;
        repeat (5) tick();
        read_chk("hold_entry3", 3'd3, 1'b1, 8'hA5, 1'b0);

        // Scan has priority over a simultaneous write.
        pulse_reset();
        tc = 1'b1; en_in = 1'b1; wr_addr = 3'd2; din = 8'hFF; td = 1'b1;
        tick();
        tc = 1'b0; en_in = 1'b0; td = 1'b0;
        read_chk("scan_prio_mem0", 3'd0, 1'b1, 8'h01, 1'b0);
        read_chk("scan_prio_mem2", 3'd2, 1'b1, 8'h00, 1'b0);

        // Full 64-edge shift of a single 1.
        pulse_reset();
        for (int n = 1; n <= 64; n++) begin
            tc = 1'b1;
            td = (n == 1);
            tick();
            read_chk($sformatf("scan_edge_%0d", n), 3'd0, 1'b0, 8'h00, (n == 64));
        end
        tc = 1'b0; td = 1'b0;
        read_chk("scan_unload_mem7", 3'd7, 1'b1, 8'h80, 1'b1);

        // Read-during-write: old value before the edge, new after.
        write(3'd5, 8'h11);
        en_in = 1'b1; wr_addr = 3'd5; din = 8'h22;
        read_chk("rdw_before", 3'd5, 1'b1, 8'h11, 1'b1);
        tick();
        en_in = 1'b0;
        read_chk("rdw_after", 3'd5, 1'b1, 8'h22, 1'b1);

        // Randomized traffic against the reference model.
        for (int n = 0; n < 400; n++) begin
            logic [2:0] ra;
            logic       re;
            tc      = ($urandom_range(0, 3) == 0);
            td      = 1'($urandom);
            en_in   = 1'($urandom);
            wr_addr = 3'($urandom);
            din     = 8'($urandom);
            ra      = 3'($urandom);
            re      = ($urandom_range(0, 4) != 0);
            read_chk($sformatf("rand_%0d", n), ra, re,
                     re ? model_byte(int'(ra)) : 8'h00, model_bits[63]);
            tick();
        end
        tc = 1'b0; en_in = 1'b0;
        read_chk("rand_final_7", 3'd7, 1'b1, model_byte(7), model_bits[63]);

        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mux_reg_8x8.md
# mux_reg_8x8

Eight-entry by 8-bit register file with a single write port, a single gated combinational read port, and a 64-bit serial test (scan) chain. It holds per-byte page/selection values loaded from a wider data bus and drives the selected byte onto a local page output. The chain gives test access to all 512... correction: all 64 storage bits through the TC/TD/TQ pins.

## Interface
- No parameters. Fixed geometry: 8 entries, 8 bits per entry.
- clk  input  1  rising-edge clock for all storage.
- reset  input  1  asynchronous, active-high; clears all entries.
- din  input  8  write data.
- en_in  input  1  write enable.
- wr_addr  input  3  write entry select.
- en_out  input  1  read output enable.
- rd_addr  input  3  read entry select.
- dout  output  8  read data.
- tc  input  1  test control; 1 selects scan shift mode.
- td  input  1  scan serial input.
- tq  output  1  scan serial output.

## Operation
- Storage: mem[0..7], each 8 bits. Bit numbering in the chain is k = 8*entry + bit, k = 0..63.
- Reset (async, reset=1): all mem entries = 8'h00 immediately. Clock is ignored while reset is high.
- Priority on each rising clk edge when reset=0:
  - tc=1 (scan shift): chain shifts one position toward bit 63. New bit 0 (mem[0][0]) = td. Each bit k>0 takes the old value of bit k-1 (so mem[e][0] takes old mem[e-1][7]). en_in is ignored.
  - tc=0, en_in=1: mem[wr_addr] = din. All other entries hold.
  - tc=0, en_in=0: all entries hold.
- Read path (combinational): dout = mem[rd_addr] when en_out=1; dout = 8'h00 when en_out=0. dout is never tri-stated.
- Read-during-write to the same entry: dout shows the old value until the clock edge, then the new value. There is no write-through bypass.
- tq = bit 63 (mem[7][7]), combinational from storage, in every mode.
- tq and dout are valid and 0 during reset.

## Timing
- Write latency: 1 clk. Data is visible on dout right after the capturing edge, given matching rd_addr and en_out=1.
- Read latency: 0 cycles. dout follows rd_addr, en_out, and storage combinationally.
- Scan: a bit presented on td reaches tq after 64 shift edges. A full 64-bit load or unload takes 64 edges with tc=1.
- Changing tc between edges is allowed. The mode is sampled at each edge.
- Reset asserted mid-scan or mid-write clears state asynchronously. Operation resumes at the first edge after reset deasserts.
- All inputs must meet setup and hold to the rising edge of clk. reset deassertion must be synchronous to clk.

## Test plan
- Reset clear: write all 8 entries with 8'hFF, then pulse reset mid-cycle. Required: dout=8'h00 for every rd_addr at once, without waiting for a clock edge, and tq=0.
- Write/read all entries: write din=8'h10+i to entry i for i=0..7, with en_out=1. Required: reading rd_addr=i gives 8'h10+i. With en_out=0, dout=8'h00.
- Hold behaviour: load entry 3 with 8'hA5, then apply 5 edges with en_in=0 and din=8'h5A. Required: entry 3 still reads 8'hA5.
- Scan priority: tc=1, en_in=1, wr_addr=2, din=8'hFF, td=1 for one edge after reset. Required: mem[0]=8'h01, mem[2]=8'h00.
- Scan full load/unload: after reset, shift 64 bits (td=1 on the first edge, 0 afterwards). Required: tq=0 after edges 1..63 and tq=1 after edge 64. Then set tc=0 and en_out=1 with rd_addr=7. Required: dout=8'h80.
- Read-during-write: rd_addr=wr_addr=5, mem[5]=8'h11, din=8'h22, en_in=1. Required: dout=8'h11 before the edge and 8'h22 after it.
